// File: rtl/brick_field.sv
// Breakout brick wall: per-brick alive state, per-frame overlap scan against the ball, and kill/retire logic.
// Optional scoring output is compiled in when BRICK_SCORE_EN is defined.
module brick_field #(
    parameter int N_BLOCKS = 17,
    parameter int COLS     = 6,
    parameter int BW       = 100,
    parameter int BH       = 20,
    parameter int GAP      = 4,
    parameter int X0       = 10,
    parameter int Y0       = 40
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ani_stb,
    input  logic                  i_start,
    input  logic [11:0]           i_bx1,
    input  logic [11:0]           i_bx2,
    input  logic [11:0]           i_by1,
    input  logic [11:0]           i_by2,
    input  logic [N_BLOCKS-1:0]   i_col_detected,
    output logic [2*N_BLOCKS-1:0] o_hit_block,
    output logic [N_BLOCKS-1:0]   o_alive,
    output logic [4:0]            o_remaining,
`ifdef BRICK_SCORE_EN
    output logic [9:0]            o_score,
`endif
    output logic                  o_cleared
);

    localparam int N_ROWS = (N_BLOCKS + COLS - 1) / COLS;
    localparam int IDX_W  = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = $clog2(N_ROWS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BLOCKS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [2*N_BLOCKS-1:0] shadow_q, shadow_d;
    logic [2*N_BLOCKS-1:0] hit_q, hit_d;
    logic [N_BLOCKS-1:0]   alive_q, alive_d;
    logic [N_BLOCKS-1:0]   kill_q;
    logic [4:0]            remaining_q, remaining_d;
`ifdef BRICK_SCORE_EN
    logic [9:0]            score_q, score_d;
    logic [10:0]           score_sum;
`endif

    logic [N_BLOCKS-1:0]   kill_vec;
    logic [4:0]            kill_cnt;

    logic [12:0] brick_l, brick_r, brick_t, brick_b;
    logic [12:0] ball_l, ball_r, ball_t, ball_b;
    logic [12:0] dx_a, dx_b, dy_a, dy_b, px, py;
    logic        overlap;
    logic [1:0]  cls;

    // A kill is a rising edge of the sticky flag on a brick that is still alive.
    for (genvar gi = 0; gi < N_BLOCKS; gi++) begin : g_kill
        assign kill_vec[gi] = i_col_detected[gi] & ~kill_q[gi] & alive_q[gi];
    end

    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < N_BLOCKS; i++) begin
            kill_cnt = kill_cnt + 5'(kill_vec[i]);
        end
    end

    // Geometry of the brick currently being visited, from the row/column counters.
    always_comb begin
        brick_l = 13'(X0) + 13'(col_q) * 13'(BW + GAP);
        brick_r = brick_l + 13'(BW - 1);
        brick_t = 13'(Y0) + 13'(row_q) * 13'(BH + GAP);
        brick_b = brick_t + 13'(BH - 1);
        ball_l  = 13'(i_bx1);
        ball_r  = 13'(i_bx2);
        ball_t  = 13'(i_by1);
        ball_b  = 13'(i_by2);
        dx_a    = ball_r - brick_l;
        dx_b    = brick_r - ball_l;
        dy_a    = ball_b - brick_t;
        dy_b    = brick_b - ball_t;
        px      = (dx_a < dx_b) ? dx_a : dx_b;
        py      = (dy_a < dy_b) ? dy_a : dy_b;
        overlap = (ball_l <= brick_r) && (ball_r >= brick_l) &&
                  (ball_t <= brick_b) && (ball_b >= brick_t) && alive_q[idx_q];
        cls = 2'b00;
        if (overlap) begin
            if (py < px)      cls = 2'b01;
            else if (px < py) cls = 2'b10;
            else              cls = 2'b11;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ani_stb) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Kill masking is applied last so it overrides both the scan write and the commit copy.
    always_comb begin
        shadow_d = shadow_q;
        hit_d    = hit_q;
        alive_d  = alive_q & ~kill_vec;
        if (state_q == ST_SCAN) begin
            shadow_d[2*idx_q +: 2] = cls;
        end
        if (state_q == ST_COMMIT) begin
            hit_d = shadow_q;
        end
        for (int i = 0; i < N_BLOCKS; i++) begin
            if (kill_vec[i]) begin
                shadow_d[2*i +: 2] = 2'b00;
                hit_d[2*i +: 2]    = 2'b00;
            end
        end
        remaining_d = (kill_cnt >= remaining_q) ? 5'd0 : remaining_q - kill_cnt;
    end

`ifdef BRICK_SCORE_EN
    always_comb begin
        score_sum = 11'(score_q) + 11'(kill_cnt) * 11'd5;
        score_d   = (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            shadow_q    <= '0;
            hit_q       <= '0;
            alive_q     <= '1;
            kill_q      <= i_col_detected;
            remaining_q <= 5'(N_BLOCKS);
`ifdef BRICK_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            shadow_q    <= shadow_d;
            hit_q       <= hit_d;
            alive_q     <= alive_d;
            kill_q      <= i_col_detected;
            remaining_q <= remaining_d;
`ifdef BRICK_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign o_hit_block = hit_q;
    assign o_alive     = alive_q;
    assign o_remaining = remaining_q;
    assign o_cleared   = (remaining_q == 5'd0);
`ifdef BRICK_SCORE_EN
    assign o_score     = score_q;
`endif

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: scan latency, hit classification, kill/restore and full clear.
// Score checks are active when BRICK_SCORE_EN is defined.
module tb_brick_field;

    localparam int N = 17;

    logic           clk = 1'b0;
    logic           rst, stb, start;
    logic [11:0]    bx1, bx2, by1, by2;
    logic [N-1:0]   col;
    logic [2*N-1:0] hit;
    logic [N-1:0]   alive;
    logic [4:0]     rem;
    logic           cleared;
`ifdef BRICK_SCORE_EN
    logic [9:0]     score;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    brick_field dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ani_stb      (stb),
        .i_start        (start),
        .i_bx1          (bx1),
        .i_bx2          (bx2),
        .i_by1          (by1),
        .i_by2          (by2),
        .i_col_detected (col),
        .o_hit_block    (hit),
        .o_alive        (alive),
        .o_remaining    (rem),
`ifdef BRICK_SCORE_EN
        .o_score        (score),
`endif
        .o_cleared      (cleared)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ball(input logic [11:0] l, input logic [11:0] r,
                            input logic [11:0] t, input logic [11:0] b);
        bx1 = l; bx2 = r; by1 = t; by2 = b;
    endtask

    // Strobe, optionally re-strobe at edge 5, and return just after edge 17 (one before commit).
    task automatic scan_to_last(input bit mid_strobe);
        stb = 1'b1;
        tick();
        stb = 1'b0;
        if (mid_strobe) begin
            repeat (4) tick();
            stb = 1'b1;
            tick();
            stb = 1'b0;
            repeat (12) tick();
        end else begin
            repeat (17) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        checks++; if (alive !== 17'h1FFFF) begin errors++; $display("FAIL reset_alive: got %h want %h", alive, 17'h1FFFF); end
        checks++; if (rem !== 5'd17) begin errors++; $display("FAIL reset_remaining: got %0d want 17", rem); end
        checks++; if (hit !== 34'h0) begin errors++; $display("FAIL reset_hit: got %h want 0", hit); end
        checks++; if (cleared !== 1'b0) begin errors++; $display("FAIL reset_cleared: got %b want 0", cleared); end
`ifdef BRICK_SCORE_EN
        checks++; if (score !== 10'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
`endif
        $display("reset: alive=%h remaining=%0d", alive, rem);
    endtask

    task automatic test_edge_hit();
        // Brick 0 only: px=min(49,59)=49, py=min(22,2)=2 -> 01.
        set_ball(12'd50, 12'd59, 12'd57, 12'd62);
        scan_to_last(1'b0);
        checks++; if (hit !== 34'h0) begin errors++; $display("FAIL edge_before_commit: got %h want 0", hit); end
        tick();
        checks++; if (hit !== 34'h1) begin errors++; $display("FAIL edge_hit: got %h want 1", hit); end
        $display("scan edge: hit=%h", hit);
    endtask

    task automatic test_corner();
        // Bricks 0 and 1 both see px=py=2 -> 11 in pairs 0 and 1.
        set_ball(12'd107, 12'd116, 12'd57, 12'd62);
        scan_to_last(1'b0);
        checks++; if (hit !== 34'h1) begin errors++; $display("FAIL corner_before_commit: got %h want 1", hit); end
        tick();
        checks++; if (hit !== 34'hF) begin errors++; $display("FAIL corner_hit: got %h want f", hit); end
        $display("scan corner: hit=%h", hit);
    endtask

    task automatic test_side();
        // Brick 0: px=4, py=2 -> 01. Brick 1: px=0, py=2 -> 10.
        set_ball(12'd105, 12'd114, 12'd57, 12'd62);
        scan_to_last(1'b0);
        tick();
        checks++; if (hit !== 34'h9) begin errors++; $display("FAIL side_hit: got %h want 9", hit); end
        $display("scan side: hit=%h", hit);
    endtask

    task automatic test_back_to_back();
        // Bricks 7 and 8 side hits (px 3/1 < py 13) -> pairs 7 and 8 = 10.
        set_ball(12'd210, 12'd219, 12'd70, 12'd79);
        scan_to_last(1'b1);
        checks++; if (hit !== 34'h9) begin errors++; $display("FAIL restrobe_before_commit: got %h want 9", hit); end
        tick();
        checks++; if (hit !== 34'h28000) begin errors++; $display("FAIL restrobe_commit: got %h want 28000", hit); end
        repeat (6) tick();
        checks++; if (hit !== 34'h28000) begin errors++; $display("FAIL restrobe_hold: got %h want 28000", hit); end
        $display("scan with mid-scan strobe: hit=%h", hit);
    endtask

    task automatic test_kill_restore();
        // Brick 5 spans x 530..629, y 40..59: px=49, py=14 -> 01 in pair 5.
        set_ball(12'd570, 12'd579, 12'd45, 12'd54);
        scan_to_last(1'b0);
        tick();
        checks++; if (hit !== 34'h400) begin errors++; $display("FAIL brick5_hit: got %h want 400", hit); end
        col[5] = 1'b1;
        tick();
        checks++; if (alive !== 17'h1FFDF) begin errors++; $display("FAIL kill_alive: got %h want 1ffdf", alive); end
        checks++; if (rem !== 5'd16) begin errors++; $display("FAIL kill_remaining: got %0d want 16", rem); end
        checks++; if (hit !== 34'h0) begin errors++; $display("FAIL kill_zero_pair: got %h want 0", hit); end
`ifdef BRICK_SCORE_EN
        checks++; if (score !== 10'd5) begin errors++; $display("FAIL kill_score: got %0d want 5", score); end
`endif
        scan_to_last(1'b0);
        tick();
        checks++; if (hit !== 34'h0) begin errors++; $display("FAIL dead_brick_hit: got %h want 0", hit); end
        checks++; if (rem !== 5'd16) begin errors++; $display("FAIL held_flag_remaining: got %0d want 16", rem); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (alive !== 17'h1FFFF) begin errors++; $display("FAIL restart_alive: got %h want 1ffff", alive); end
        repeat (5) tick();
        checks++; if (alive[5] !== 1'b1) begin errors++; $display("FAIL restart_sticky: got %b want 1", alive[5]); end
        checks++; if (rem !== 5'd17) begin errors++; $display("FAIL restart_remaining: got %0d want 17", rem); end
`ifdef BRICK_SCORE_EN
        checks++; if (score !== 10'd0) begin errors++; $display("FAIL restart_score: got %0d want 0", score); end
`endif
        col = '0;
        tick();
        $display("kill/restore: alive=%h remaining=%0d", alive, rem);
    endtask

    task automatic test_clear_all();
        col = '1;
        tick();
        checks++; if (rem !== 5'd0) begin errors++; $display("FAIL clear_remaining: got %0d want 0", rem); end
        checks++; if (cleared !== 1'b1) begin errors++; $display("FAIL clear_flag: got %b want 1", cleared); end
        checks++; if (alive !== 17'h0) begin errors++; $display("FAIL clear_alive: got %h want 0", alive); end
`ifdef BRICK_SCORE_EN
        checks++; if (score !== 10'd85) begin errors++; $display("FAIL clear_score: got %0d want 85", score); end
`endif
        tick();
        checks++; if (rem !== 5'd0) begin errors++; $display("FAIL clear_saturate: got %0d want 0", rem); end
        col = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (rem !== 5'd17 || cleared !== 1'b0) begin errors++; $display("FAIL clear_restart: got rem=%0d cleared=%b want 17/0", rem, cleared); end
        $display("clear all: remaining=%0d cleared=%b", rem, cleared);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; start = 1'b0; col = '0;
        set_ball(12'd0, 12'd0, 12'd0, 12'd0);
        test_reset();
        test_edge_hit();
        test_corner();
        test_side();
        test_back_to_back();
        test_kill_restore();
        test_clear_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
